// File: rtl/fp_dec_pkg.sv
// Shared constants, FSM encoding and helpers for the FloatToNum decimal output path.
package fp_dec_pkg;

  localparam int FRAC_W = 24;
  localparam int ACC_W  = 28;
  localparam int DIG_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Integer part of an accumulator-format value: the bits above the fraction.
  function automatic logic [DIG_W-1:0] int_part(input logic [ACC_W-1:0] v);
    return v[ACC_W-1 -: DIG_W];
  endfunction

endpackage

// File: rtl/frac_digit_seq_chk.sv
// Simulation checks for frac_digit_seq: the x10 product must always yield a decimal digit.
module frac_digit_seq_chk
  import fp_dec_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  input logic             in_run,
  input logic [ACC_W-1:0] prod,
  input logic             prod_cout
);

  // acc stays below 2^24 in RUN, so acc*10 has an integer part of at most 9
  a_digit_range: assert property (@(posedge clk) disable iff (!rst_n)
                                  in_run |-> (int_part(prod) <= 4'd9))
    else $error("frac_digit_seq: product integer part above 9");

  a_no_wrap: assert property (@(posedge clk) disable iff (!rst_n)
                              in_run |-> !prod_cout)
    else $error("frac_digit_seq: x10 product overflowed the accumulator");

endmodule

// File: rtl/nhan10_28bit.sv
// Shared x10 unit: dout = din*10 mod 2^28, with the overflow bits folded into cout.
module nhan10_28bit
  import fp_dec_pkg::*;
(
  input  logic [ACC_W-1:0] din,
  output logic [ACC_W-1:0] dout,
  output logic             cout
);

  logic [ACC_W+3:0] full_s;

  // din*10 as (din<<3) + (din<<1), wide enough to never lose a bit
  assign full_s = {1'b0, din, 3'b000} + {3'b000, din, 1'b0};
  assign dout   = full_s[ACC_W-1:0];
  assign cout   = |full_s[ACC_W+3:ACC_W];

endmodule

// File: rtl/frac_digit_seq.sv
// Turns a binary fraction into truncated decimal digits, MSD first, one x10 step per digit,
// with a start/busy/done control handshake and a valid/ready digit stream.
module frac_digit_seq
  import fp_dec_pkg::*;
#(
  parameter int FRAC_W = 24,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [FRAC_W-1:0] frac,
  input  logic [CNT_W-1:0]  ndig,
  output logic              busy,
  output logic [DIG_W-1:0]  digit,
  output logic [CNT_W-1:0]  digit_idx,
  output logic              digit_valid,
  input  logic              digit_ready,
  output logic              done,
  output logic              exact
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [DIG_W-1:0]   dig_q, dig_d;
  logic [CNT_W-1:0]   didx_q, didx_d;
  logic               dval_q, dval_d;
  logic [ACC_W-1:0]   prod_s;
  logic               prod_cout_s;
  logic               slot_free_s;

  // The x10 wrap is intended: only the low fraction bits are fed back.
  nhan10_28bit u_x10 (
    .din  (acc_q),
    .dout (prod_s),
    .cout (prod_cout_s)
  );

  frac_digit_seq_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_run    (state_q == RUN),
    .prod      (prod_s),
    .prod_cout (prod_cout_s)
  );

  assign slot_free_s = !dval_q || digit_ready;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (slot_free_s && (rem_q == {CNT_W{1'b0}})) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load on start, emit one digit per free slot in RUN
  always_comb begin
    acc_d  = acc_q;
    rem_d  = rem_q;
    idx_d  = idx_q;
    dig_d  = dig_q;
    didx_d = didx_q;
    dval_d = dval_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = {{(ACC_W-FRAC_W){1'b0}}, frac};
          rem_d = ndig;
          idx_d = {CNT_W{1'b0}};
        end else begin
          acc_d = acc_q;
        end
      end
      RUN: begin
        if (slot_free_s) begin
          if (rem_q != {CNT_W{1'b0}}) begin
            dig_d  = int_part(prod_s);
            didx_d = idx_q;
            dval_d = 1'b1;
            acc_d  = {{(ACC_W-FRAC_W){1'b0}}, prod_s[FRAC_W-1:0]};
            rem_d  = rem_q - {{(CNT_W-1){1'b0}}, 1'b1};
            idx_d  = idx_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            dval_d = 1'b0;
          end
        end else begin
          dval_d = dval_q;
        end
      end
      DONE:    dval_d = 1'b0;
      default: dval_d = 1'b0;
    endcase
  end

  // Datapath and digit-stream registers; a reset drops any pending digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= {ACC_W{1'b0}};
      rem_q  <= {CNT_W{1'b0}};
      idx_q  <= {CNT_W{1'b0}};
      dig_q  <= {DIG_W{1'b0}};
      didx_q <= {CNT_W{1'b0}};
      dval_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      rem_q  <= rem_d;
      idx_q  <= idx_d;
      dig_q  <= dig_d;
      didx_q <= didx_d;
      dval_q <= dval_d;
    end
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    exact = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
      end
      RUN: begin
        busy = 1'b1;
      end
      DONE: begin
        busy  = 1'b1;
        done  = 1'b1;
        exact = (acc_q == {ACC_W{1'b0}});
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign digit       = dig_q;
  assign digit_idx   = didx_q;
  assign digit_valid = dval_q;

endmodule

// File: tb/tb_frac_digit_seq.sv
// Self-checking bench for frac_digit_seq: directed plan cases plus randomized jobs
// compared every cycle against a long-division reference of the fraction.
module tb_frac_digit_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [23:0] frac;
  logic [3:0]  ndig;
  logic        busy;
  logic [3:0]  digit;
  logic [3:0]  digit_idx;
  logic        digit_valid;
  logic        digit_ready;
  logic        done;
  logic        exact;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;

  // reference model state
  int exp_q[$];
  int exp_idx   = 0;
  bit exp_exact = 1'b0;
  bit job_on    = 1'b0;

  // observation log
  int got_dig[$];
  int got_cyc[$];
  int want[$];
  int done_cnt   = 0;
  int done_cyc   = -1;
  bit done_exact = 1'b0;

  bit         prev_stall = 1'b0;
  logic [3:0] prev_dig   = 4'd0;
  logic [3:0] prev_idx   = 4'd0;

  frac_digit_seq #(.FRAC_W(24), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .frac        (frac),
    .ndig        (ndig),
    .busy        (busy),
    .digit       (digit),
    .digit_idx   (digit_idx),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .done        (done),
    .exact       (exact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  // Decimal expansion by repeated multiply-by-ten of frac/2^24, truncated.
  task automatic model_load(input logic [23:0] f, input logic [3:0] n);
    longint x;
    x = longint'(f);
    exp_q.delete();
    for (int i = 0; i < int'(n); i++) begin
      x = x * 10;
      exp_q.push_back(int'(x / 64'd16777216));
      x = x % 64'd16777216;
    end
    exp_exact = (x == 0);
    exp_idx   = 0;
    job_on    = 1'b1;
  endtask

  // Single compare process: every cycle, DUT outputs against the reference.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (job_on) begin
        chk("busy_in_job", {31'd0, busy}, 32'd1);
        if (prev_stall)
          chk("hold_stable", {23'd0, digit_valid, digit, digit_idx}, {23'd0, 1'b1, prev_dig, prev_idx});
        if (digit_valid) begin
          chk("digit_expected", exp_q.size(), (exp_q.size() > 0) ? exp_q.size() : 1);
          if (exp_q.size() > 0) begin
            chk("digit_value", {28'd0, digit}, exp_q[0]);
            chk("digit_idx", {28'd0, digit_idx}, exp_idx);
            if (digit_ready) begin
              void'(exp_q.pop_front());
              exp_idx++;
              got_dig.push_back(int'(digit));
              got_cyc.push_back(cyc);
            end
          end
        end
        if (done) begin
          chk("digits_left_at_done", exp_q.size(), 0);
          chk("exact_at_done", {31'd0, exact}, {31'd0, exp_exact});
          done_cnt++;
          done_cyc   = cyc;
          done_exact = exact;
          job_on     = 1'b0;
        end
      end else begin
        chk("idle_outputs", {28'd0, busy, digit_valid, done, exact}, 32'd0);
      end
      prev_stall = digit_valid && !digit_ready;
      prev_dig   = digit;
      prev_idx   = digit_idx;
    end
  end

  task automatic start_job(input logic [23:0] f, input logic [3:0] n);
    got_dig.delete();
    got_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
    frac  = f;
    ndig  = n;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0    = cyc - 1;
    model_load(f, n);
    frac = 24'($urandom);
    ndig = 4'($urandom);
  endtask

  // mode 0: ready held high, 1: random ready, 2: ready left as is
  task automatic wait_job(input int mode, input int n, input bit poke);
    for (int k = 0; k < 300 && job_on; k++) begin
      if (mode == 0) digit_ready = 1'b1;
      else if (mode == 1) digit_ready = 1'($urandom_range(0, 1));
      if (poke && cyc == t0 + 3) begin
        start = 1'b1;
        frac  = 24'hFFFFFF;
        ndig  = 4'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("job_finished", {31'd0, job_on}, 32'd0);
    job_on = 1'b0;
    exp_q.delete();
    if (mode == 0) chk("done_cycle", done_cyc, t0 + n + 2);
  endtask

  task automatic chk_got(input string nm);
    chk({nm, "_count"}, got_dig.size(), want.size());
    for (int i = 0; i < want.size(); i++)
      chk({nm, "_digit"}, (i < got_dig.size()) ? got_dig[i] : -1, want[i]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] rf;
    logic [3:0]  rn;
    rst_n       = 1'b0;
    start       = 1'b0;
    frac        = 24'd0;
    ndig        = 4'd0;
    digit_ready = 1'b1;
    #1;
    chk("reset_outputs", {20'd0, busy, digit, digit_idx, digit_valid, done, exact}, 32'd0);
    #22 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 0.5 -> 5,0,0 at T+2..T+4, done at T+5, exact
    start_job(24'h800000, 4'd3);
    wait_job(0, 3, 1'b0);
    want = '{5, 0, 0};
    chk_got("half");
    chk("half_first_cycle", (got_cyc.size() > 0) ? got_cyc[0] : -1, t0 + 2);
    chk("half_last_cycle", (got_cyc.size() > 2) ? got_cyc[2] : -1, t0 + 4);
    chk("half_done_cycle", done_cyc, t0 + 5);
    chk("half_exact", {31'd0, done_exact}, 32'd1);
    chk("half_done_count", done_cnt, 1);

    // backpressure: 0.75, ready low for three cycles while 7 is presented
    digit_ready = 1'b0;
    start_job(24'hC00000, 4'd2);
    for (int k = 0; k < 10 && !digit_valid; k++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", {23'd0, digit_valid, digit, digit_idx}, {23'd0, 1'b1, 4'd7, 4'd0});
      if (i < 2) @(negedge clk);
    end
    @(posedge clk);
    #1;
    digit_ready = 1'b1;
    wait_job(2, 2, 1'b0);
    want = '{7, 5};
    chk_got("bp");
    chk("bp_exact", {31'd0, done_exact}, 32'd1);

    // inexact ~0.1
    start_job(24'h19999A, 4'd8);
    wait_job(0, 8, 1'b0);
    want = '{1, 0, 0, 0, 0, 0, 0, 2};
    chk_got("tenth");
    chk("tenth_exact", {31'd0, done_exact}, 32'd0);

    // ndig = 0
    start_job(24'h000000, 4'd0);
    wait_job(0, 0, 1'b0);
    chk("n0_zero_digits", got_dig.size(), 0);
    chk("n0_zero_done_cycle", done_cyc, t0 + 2);
    chk("n0_zero_exact", {31'd0, done_exact}, 32'd1);
    start_job(24'h400000, 4'd0);
    wait_job(0, 0, 1'b0);
    chk("n0_quarter_digits", got_dig.size(), 0);
    chk("n0_quarter_exact", {31'd0, done_exact}, 32'd0);

    // start while busy is ignored
    start_job(24'h200000, 4'd4);
    wait_job(0, 4, 1'b1);
    want = '{1, 2, 5, 0};
    chk_got("busy_start");
    repeat (5) @(posedge clk);
    #1;
    chk("busy_start_done_count", done_cnt, 1);

    // asynchronous reset mid-RUN with a digit pending
    digit_ready = 1'b0;
    start_job(24'h19999A, 4'd8);
    for (int k = 0; k < 10 && !digit_valid; k++) @(negedge clk);
    chk("rst_pre_valid", {31'd0, digit_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {20'd0, busy, digit, digit_idx, digit_valid, done, exact}, 32'd0);
    job_on = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    digit_ready = 1'b1;
    start_job(24'h800000, 4'd3);
    wait_job(0, 3, 1'b0);
    want = '{5, 0, 0};
    chk_got("post_rst");
    chk("post_rst_done_count", done_cnt, 1);

    // randomized jobs, alternating steady and random ready
    for (int j = 0; j < 40; j++) begin
      rf = 24'($urandom);
      if (j % 5 == 0) rf = rf & 24'hF00000;
      rn = 4'($urandom_range(0, 15));
      start_job(rf, rn);
      wait_job(j % 2, int'(rn), 1'b0);
      chk("rand_done_count", done_cnt, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
